// File: rtl/planificador_sensores_if.sv
// Sensor-side handshake and monitor-core bus shared by the round-robin scheduler.
// The master modport is the scheduler; the slave modport is the sensors plus the monitor core.
interface planificador_sensores_if #(
    parameter int N_SENS = 4
);
    logic [N_SENS-1:0]      sens_valid;
    logic [11*N_SENS-1:0]   sens_temp;
    logic [N_SENS-1:0]      sens_ready;
    logic signed [10:0]     mon_temp;
    logic                   mon_valid;
    logic [1:0]             mon_estado;
    logic                   mon_alerta;

    modport master (
        input  sens_valid, sens_temp, mon_estado, mon_alerta,
        output sens_ready, mon_temp, mon_valid
    );

    modport slave (
        output sens_valid, sens_temp, mon_estado, mon_alerta,
        input  sens_ready, mon_temp, mon_valid
    );
endinterface

// File: rtl/planificador_sensores.sv
// Round-robin scheduler sharing one temperature-monitor core among N_SENS zones.
// Clamps the chosen reading, waits out the monitor latency and stores per-zone status.
module planificador_sensores #(
    parameter int                 N_SENS  = 4,
    parameter int                 LAT_MON = 2,
    parameter logic signed [10:0] T_MIN   = -11'sd500,
    parameter logic signed [10:0] T_MAX   = 11'sd1000
) (
    input  logic                    clk,
    input  logic                    arst_n,
    planificador_sensores_if.master bus,
    output logic [2*N_SENS-1:0]     zona_estado,
    output logic [N_SENS-1:0]       zona_alerta,
    output logic [N_SENS-1:0]       zona_fuera,
    output logic                    alerta_global,
    output logic [2:0]              zona_activa,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_SETTLE  = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_ptr;
    logic [2:0]          r_sel;
    logic [3:0]          r_cnt;
    logic signed [10:0]  r_mon_temp;
    logic                r_fuera_pend;
    logic [2*N_SENS-1:0] r_zona_estado;
    logic [N_SENS-1:0]   r_zona_alerta;
    logic [N_SENS-1:0]   r_zona_fuera;

    logic [N_SENS-1:0]   w_valid_rot;
    logic                w_any;
    logic [2:0]          w_sel;
    logic signed [10:0]  w_raw;
    logic signed [10:0]  w_clamped;
    logic                w_fuera;
    logic [N_SENS-1:0]   w_ready;
    logic                w_mon_valid;

    // Modular add for zone indices; both operands are always below N_SENS.
    function automatic logic [2:0] wrap_add(input logic [2:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_SENS) s = s - N_SENS;
        return 3'(s);
    endfunction

    // Rotate the request vector so bit 0 is the zone at the pointer; lowest set bit wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_valid_rot = N_SENS'({bus.sens_valid, bus.sens_valid} >> r_ptr);
        w_any       = |w_valid_rot;
        w_sel       = r_ptr;
        for (int k = N_SENS - 1; k >= 0; k--) begin
            if (w_valid_rot[k]) w_sel = wrap_add(r_ptr, k);
        end

        w_raw = '0;
        for (int k = 0; k < N_SENS; k++) begin
            if (k == int'(w_sel)) w_raw = bus.sens_temp[11*k +: 11];
        end

        w_clamped = w_raw;
        w_fuera   = 1'b0;
        if (w_raw > T_MAX) begin
            w_clamped = T_MAX;
            w_fuera   = 1'b1;
        end else if (w_raw < T_MIN) begin
            w_clamped = T_MIN;
            w_fuera   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        // NOTE: state and data registers use non-blocking assignments so all flops update together.
        if (!arst_n) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_mon_valid  = 1'b0;
        w_ready      = '0;
        case (r_state)
            S_IDLE:    if (w_any) w_state_next = S_GRANT;
            S_GRANT: begin
                w_mon_valid  = 1'b1;
                for (int k = 0; k < N_SENS; k++) begin
                    if (k == int'(r_sel)) w_ready[k] = 1'b1;
                end
                w_state_next = S_SETTLE;
            end
            S_SETTLE:  if (r_cnt == 4'd0) w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_ptr         <= '0;
            r_sel         <= '0;
            r_cnt         <= '0;
            r_mon_temp    <= '0;
            r_fuera_pend  <= 1'b0;
            r_zona_estado <= '0;
            r_zona_alerta <= '0;
            r_zona_fuera  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_sel        <= w_sel;
                        r_mon_temp   <= w_clamped;
                        r_fuera_pend <= w_fuera;
                    end
                end
                S_GRANT:  r_cnt <= 4'(LAT_MON - 1);
                S_SETTLE: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                S_CAPTURE: begin
                    for (int k = 0; k < N_SENS; k++) begin
                        if (k == int'(r_sel)) begin
                            r_zona_estado[2*k +: 2] <= bus.mon_estado;
                            r_zona_alerta[k]        <= bus.mon_alerta;
                            r_zona_fuera[k]         <= r_fuera_pend;
                        end
                    end
                    r_ptr <= wrap_add(r_sel, 1);
                end
                default: ;
            endcase
        end
    end

    assign bus.mon_temp   = r_mon_temp;
    assign bus.mon_valid  = w_mon_valid;
    assign bus.sens_ready = w_ready;
    assign zona_estado    = r_zona_estado;
    assign zona_alerta    = r_zona_alerta;
    assign zona_fuera     = r_zona_fuera;
    assign alerta_global  = |r_zona_alerta;
    assign zona_activa    = r_sel;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_planificador_sensores.sv
// Directed bench for planificador_sensores: reset, single zone, fairness, clamp, alarm, reset mid-sample.
// The monitor stub returns the inverse of the intended result until LAT_MON cycles after mon_valid.
module tb_planificador_sensores;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           arst_n;
    logic [2*N-1:0] zona_estado;
    logic [N-1:0]   zona_alerta;
    logic [N-1:0]   zona_fuera;
    logic           alerta_global;
    logic [2:0]     zona_activa;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [1:0] stub_estado;
    logic       stub_alerta;
    int         stub_cnt;

    always #5 clk = ~clk;

    planificador_sensores_if #(.N_SENS(N)) bus ();

    planificador_sensores #(
        .N_SENS (N),
        .LAT_MON(LAT),
        .T_MIN  (-11'sd500),
        .T_MAX  (11'sd1000)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .bus          (bus),
        .zona_estado  (zona_estado),
        .zona_alerta  (zona_alerta),
        .zona_fuera   (zona_fuera),
        .alerta_global(alerta_global),
        .zona_activa  (zona_activa),
        .busy         (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor model: wrong values right after a sample, real values once the latency has elapsed.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stub_cnt       <= 0;
            bus.mon_estado <= 2'b00;
            bus.mon_alerta <= 1'b0;
        end else if (bus.mon_valid) begin
            stub_cnt       <= 1;
            bus.mon_estado <= ~stub_estado;
            bus.mon_alerta <= ~stub_alerta;
        end else if (stub_cnt != 0) begin
            if (stub_cnt + 1 >= LAT) begin
                stub_cnt       <= 0;
                bus.mon_estado <= stub_estado;
                bus.mon_alerta <= stub_alerta;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mon_valid === 1'b1) return;
        end
        check("grant_timeout", bus.mon_valid, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b0) return;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic set_temp(input int z, input int t);
        bus.sens_temp[11*z +: 11] = 11'(t);
    endtask

    task automatic serve(input string tag, input int z, input int t, input logic [1:0] e,
                         input logic a, input int exp_t, input int exp_f);
        stub_estado    = e;
        stub_alerta    = a;
        set_temp(z, t);
        bus.sens_valid = 4'(1 << z);
        wait_grant();
        check({tag, "_activa"}, zona_activa, z);
        check({tag, "_mon_temp"}, bus.mon_temp, exp_t);
        check({tag, "_ready"}, bus.sens_ready, 1 << z);
        bus.sens_valid = '0;
        wait_idle();
        check({tag, "_estado"}, zona_estado[2*z +: 2], e);
        check({tag, "_alerta"}, zona_alerta[z], a);
        check({tag, "_fuera"}, zona_fuera[z], exp_f);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int prev;
        arst_n         = 1'b0;
        bus.sens_valid = '0;
        bus.sens_temp  = '0;
        stub_estado    = 2'b00;
        stub_alerta    = 1'b0;

        // Reset and quiet idle
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mon_valid", bus.mon_valid, 0);
        check("rst_zona_estado", zona_estado, 0);
        arst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_activa", zona_activa, 0);

        // Fairness with all zones requesting continuously
        stub_estado = 2'b11;
        stub_alerta = 1'b0;
        for (int k = 0; k < N; k++) set_temp(k, 100 * (k + 1));
        bus.sens_valid = 4'b1111;
        prev = 0;
        for (int g = 0; g < 6; g++) begin
            wait_grant();
            check("fair_zone", zona_activa, g % 4);
            check("fair_temp", bus.mon_temp, 100 * (g % 4 + 1));
            if (g > 0) check("fair_gap", cyc - prev, 5);
            prev = cyc;
            if (g == 5) bus.sens_valid = '0;
        end
        wait_idle();
        check("fair_estado_all", zona_estado, 8'hFF);

        // Single zone, cycle-exact capture timing
        stub_estado = 2'b01;
        stub_alerta = 1'b0;
        set_temp(2, 250);
        bus.sens_valid = 4'b0100;
        @(negedge clk);
        check("one_mon_valid", bus.mon_valid, 1);
        check("one_ready", bus.sens_ready, 4'b0100);
        check("one_mon_temp", bus.mon_temp, 250);
        bus.sens_valid = '0;
        @(negedge clk);
        check("one_mon_valid_pulse", bus.mon_valid, 0);
        check("one_ready_pulse", bus.sens_ready, 0);
        repeat (2) @(negedge clk);
        check("one_estado_early", zona_estado[5:4], 2'b11);
        check("one_busy_capture", busy, 1);
        @(negedge clk);
        check("one_estado", zona_estado[5:4], 2'b01);
        check("one_busy_done", busy, 0);
        check("one_fuera", zona_fuera[2], 0);

        // Clamp rule on zone 1
        serve("clamp_hi", 1, 1023, 2'b10, 1'b0, 1000, 1);
        serve("clamp_lo", 1, -1024, 2'b01, 1'b0, -500, 1);
        serve("edge_max", 1, 1000, 2'b00, 1'b0, 1000, 0);
        serve("edge_min", 1, -500, 2'b10, 1'b0, -500, 0);
        check("clamp_zone2_kept", zona_estado[5:4], 2'b01);

        // Alarm set and clear on zone 3
        serve("alarm_on", 3, 50, 2'b10, 1'b1, 50, 0);
        check("alarm_global_on", alerta_global, 1);
        serve("alarm_off", 3, 60, 2'b00, 1'b0, 60, 0);
        check("alarm_global_off", alerta_global, 0);
        check("alarm_zone2_kept", zona_estado[5:4], 2'b01);
        check("alarm_zone1_kept", zona_estado[3:2], 2'b10);

        // Reset during SETTLE with the counter at 1
        stub_estado = 2'b10;
        stub_alerta = 1'b1;
        set_temp(2, 300);
        bus.sens_valid = 4'b0100;
        wait_grant();
        bus.sens_valid = '0;
        @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mon_temp", bus.mon_temp, 0);
        check("mid_rst_mon_valid", bus.mon_valid, 0);
        check("mid_rst_ready", bus.sens_ready, 0);
        check("mid_rst_estado", zona_estado, 0);
        check("mid_rst_alerta", zona_alerta, 0);
        check("mid_rst_fuera", zona_fuera, 0);
        check("mid_rst_global", alerta_global, 0);
        check("mid_rst_activa", zona_activa, 0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_estado", zona_estado, 0);
        check("post_rst_alerta", zona_alerta, 0);
        check("post_rst_busy", busy, 0);
        set_temp(1, 10);
        set_temp(3, 30);
        bus.sens_valid = 4'b1010;
        wait_grant();
        check("post_rst_first", zona_activa, 1);
        wait_grant();
        check("post_rst_second", zona_activa, 3);
        bus.sens_valid = '0;
        wait_idle();
        check("post_rst_z3_alerta", zona_alerta, 4'b1010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
